// File: rtl/mp_mem_pkg.sv
// mp_mem_pkg: shared types and helpers for the shared-memory controller.
//   cid_w_f / len_w_f : width derivations for core index and burst length
//   state_e           : controller FSM states
//   beat_tag_t        : {core_id, burst_id} tag carried with returned read data
//                       (fields sized for the largest supported configuration)
package mp_mem_pkg;

   function automatic int cid_w_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int len_w_f(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   localparam int TAG_CID_W = 3;   // up to 8 cores
   localparam int TAG_BID_W = 32;  // widest burst tag counter

   typedef struct packed {
      logic [TAG_CID_W-1:0] core_id;
      logic [TAG_BID_W-1:0] burst_id;
   } beat_tag_t;

endpackage

// File: rtl/mp_mem_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   i_req   : request vector
//   i_ptr   : index of the last winner; scanning starts at i_ptr+1 (mod N)
//   o_grant : one-hot grant of the first request found
//   o_idx   : index of that grant
//   o_valid : any request present
module rr_arbiter
   import mp_mem_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = cid_w_f(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   logic [IW-1:0] w_cand;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      // i runs 1..N so the previous winner is considered last
      for (int i = 1; i <= N; i++) begin
         w_cand = IW'((int'(i_ptr) + i) % N);
         if (!o_valid && i_req[w_cand]) begin
            o_valid         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule

// File: rtl/mp_mem_ctrl.sv
// mp_mem_ctrl: round-robin shared-memory controller with single/burst
// read and write transactions against an internal word-addressed memory.
//   clk, reset_n       : clock (rising edge), async active-low reset
//   req/we/addr/
//   burst_len/data_in  : per-core request bundle, core0 in the LSBs
//   gnt                : one-hot, high for every beat of the active burst
//   core_id, burst_id  : owner and tag of the active burst
//   rvalid, data_out,
//   rcore_id, rburst_id: read beat return, one cycle after its beat
//   busy               : controller is in a burst
//   o_dbg_state        : raw FSM state (0=IDLE, 1=BURST)
//
// Handshake: a core raises req with we/addr/burst_len stable and holds it
// until gnt; the request bundle is captured in the IDLE cycle where it wins,
// gnt follows on the next cycle and stays high for burst_len+1 beats. Each
// gnt cycle is one beat: data_in of the owner is written on the closing edge
// of a write beat. req is not looked at again until the burst finishes.
module mp_mem_ctrl
   import mp_mem_pkg::*;
#(
   parameter  int NUM_CORES = 4,
   parameter  int ADDR_W    = 16,
   parameter  int DATA_W    = 32,
   parameter  int MEM_DEPTH = 256,
   parameter  int MAX_BURST = 4,
   parameter  int BID_W     = 8,
   localparam int CID_W     = cid_w_f(NUM_CORES),
   localparam int LEN_W     = len_w_f(MAX_BURST)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        we,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES*LEN_W-1:0]  burst_len,
   input  logic [NUM_CORES*DATA_W-1:0] data_in,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [CID_W-1:0]            core_id,
   output logic [BID_W-1:0]            burst_id,
   output logic                        rvalid,
   output logic [DATA_W-1:0]           data_out,
   output logic [CID_W-1:0]            rcore_id,
   output logic [BID_W-1:0]            rburst_id,
   output logic                        busy,
   output logic                        o_dbg_state
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   state_e             r_state, w_next_state;
   logic               r_we;
   logic [IDX_W-1:0]   r_base;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_beat;
   logic [CID_W-1:0]   r_core_id;
   logic [CID_W-1:0]   r_rr_ptr;
   logic [BID_W-1:0]   r_burst_id;
   logic [BID_W-1:0]   r_bid_cnt;
   logic               r_rvalid;
   logic [DATA_W-1:0]  r_data_out;
   beat_tag_t          r_rtag;
   logic [DATA_W-1:0]  r_mem [MEM_DEPTH];

   logic [NUM_CORES-1:0] w_arb_grant;
   logic [CID_W-1:0]     w_arb_idx;
   logic                 w_arb_valid;
   logic                 w_win_we;
   logic [IDX_W-1:0]     w_win_base;
   logic [LEN_W-1:0]     w_win_len;
   logic [DATA_W-1:0]    w_wdata;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_last;
   logic                 w_unused;

   rr_arbiter #(.N(NUM_CORES)) u_arb (
      .i_req   (req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   // Winner's request bundle and the active owner's write data
   always_comb begin
      w_win_we   = 1'b0;
      w_win_base = '0;
      w_win_len  = '0;
      w_wdata    = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (w_arb_idx == CID_W'(c)) begin
            w_win_we   = we[c];
            w_win_base = addr[c*ADDR_W +: IDX_W];
            w_win_len  = burst_len[c*LEN_W +: LEN_W];
         end
         if (r_core_id == CID_W'(c)) begin
            w_wdata = data_in[c*DATA_W +: DATA_W];
         end
      end
   end

   // Index wraps naturally modulo MEM_DEPTH through the IDX_W-bit add
   assign w_idx  = r_base + IDX_W'(r_beat);
   assign w_last = (r_beat == r_len);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      gnt          = '0;
      case (r_state)
         IDLE: begin
            if (w_arb_valid) w_next_state = BURST;
         end
         BURST: begin
            gnt[r_core_id] = 1'b1;
            if (w_last) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_we       <= 1'b0;
         r_base     <= '0;
         r_len      <= '0;
         r_beat     <= '0;
         r_core_id  <= '0;
         r_rr_ptr   <= CID_W'(NUM_CORES - 1);
         r_burst_id <= '0;
         r_bid_cnt  <= '0;
         r_rvalid   <= 1'b0;
         r_data_out <= '0;
         r_rtag     <= '0;
      end else begin
         if (r_state == IDLE) begin
            if (w_arb_valid) begin
               r_we       <= w_win_we;
               r_base     <= w_win_base;
               r_len      <= w_win_len;
               r_beat     <= '0;
               r_core_id  <= w_arb_idx;
               r_burst_id <= r_bid_cnt;
               r_bid_cnt  <= r_bid_cnt + 1'b1;
            end
         end else begin
            r_beat <= w_last ? '0 : r_beat + 1'b1;
            // Last owner becomes lowest priority in the next arbitration
            if (w_last) r_rr_ptr <= r_core_id;
         end

         if (r_state == BURST && !r_we) begin
            r_rvalid            <= 1'b1;
            r_data_out          <= r_mem[w_idx];
            r_rtag.core_id      <= TAG_CID_W'(r_core_id);
            r_rtag.burst_id     <= TAG_BID_W'(r_burst_id);
         end else begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // Memory is not reset; the async reset forces IDLE, which stops writes
   always_ff @(posedge clk) begin
      if (r_state == BURST && r_we) r_mem[w_idx] <= w_wdata;
   end

   assign core_id     = r_core_id;
   assign burst_id    = r_burst_id;
   assign rvalid      = r_rvalid;
   assign data_out    = r_data_out;
   assign rcore_id    = r_rtag.core_id[CID_W-1:0];
   assign rburst_id   = r_rtag.burst_id[BID_W-1:0];
   assign busy        = (r_state == BURST);
   assign o_dbg_state = r_state;

   // Address bits above the memory index, spare tag bits and the arbiter's
   // one-hot form are intentionally left unused
   assign w_unused = ^{addr, r_rtag, w_arb_grant};

endmodule

// File: tb/tb_mp_mem_ctrl.sv
module tb_mp_mem_ctrl;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int MB    = 4;
  localparam int BW    = 8;
  localparam int CW    = 2;
  localparam int LW    = 2;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*LW-1:0] burst_len;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    gnt;
  logic [CW-1:0]   core_id, rcore_id;
  logic [BW-1:0]   burst_id, rburst_id;
  logic            rvalid, busy, dbg_state;
  logic [DW-1:0]   data_out;

  mp_mem_ctrl #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW),
    .MEM_DEPTH(DEPTH), .MAX_BURST(MB), .BID_W(BW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .burst_len(burst_len), .data_in(data_in), .gnt(gnt),
    .core_id(core_id), .burst_id(burst_id), .rvalid(rvalid),
    .data_out(data_out), .rcore_id(rcore_id), .rburst_id(rburst_id),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: memory image, last winner, next burst tag
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];
  int            m_ptr;
  int            m_bid;
  logic [DW-1:0] wdata [MB];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int c, input bit r, input bit w, input int ad, input int ln);
    req[c] = r;
    we[c]  = w;
    addr[c*AW +: AW]    = AW'(ad);
    burst_len[c*LW +: LW] = LW'(ln);
  endtask

  function automatic int pick_winner(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    chk({tag, "_data_out"}, 64'(data_out), 64'd0);
    chk({tag, "_core_id"}, 64'(core_id), 64'd0);
    chk({tag, "_burst_id"}, 64'(burst_id), 64'd0);
    chk({tag, "_rcore_id"}, 64'(rcore_id), 64'd0);
    chk({tag, "_rburst_id"}, 64'(rburst_id), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr = N - 1;
    m_bid = 0;
  endtask

  // Called in an idle cycle with the request bundle driven; runs one
  // whole burst and checks every beat against the model.
  task automatic run_burst(input bit drop);
    int w, len, base, idx;
    bit isw;
    w = pick_winner(req);
    if (w < 0) begin
      chk("no_requester", 64'(req), 64'hFFFF);
      return;
    end
    isw  = we[w];
    base = int'(addr[w*AW +: AW]) % DEPTH;
    len  = int'(burst_len[w*LW +: LW]);
    @(posedge clk); #1;
    chk("rvalid_idle", 64'(rvalid), 64'd0);
    // bundle must be ignored once arbitration is over
    we = N'($urandom);
    addr = {$urandom, $urandom};
    burst_len = N*LW'($urandom);
    for (int b = 0; b <= len; b++) begin
      chk("gnt", 64'(gnt), 64'(1 << w));
      chk("core_id", 64'(core_id), 64'(w));
      chk("burst_id", 64'(burst_id), 64'(m_bid % (1 << BW)));
      chk("busy", 64'(busy), 64'd1);
      chk("dbg_state", 64'(dbg_state), 64'd1);
      if (b == 0 && drop) req[w] = 1'b0;
      if (isw) data_in[w*DW +: DW] = wdata[b];
      else     data_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      idx = (base + b) % DEPTH;
      if (isw) begin
        m_mem[idx] = wdata[b];
        m_val[idx] = 1'b1;
        chk("rvalid_wr", 64'(rvalid), 64'd0);
      end else begin
        chk("rvalid", 64'(rvalid), 64'd1);
        chk("rcore_id", 64'(rcore_id), 64'(w));
        chk("rburst_id", 64'(rburst_id), 64'(m_bid % (1 << BW)));
        if (m_val[idx]) chk("data_out", 64'(data_out), 64'(m_mem[idx]));
      end
    end
    chk("gnt_idle", 64'(gnt), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    m_ptr = w;
    m_bid++;
  endtask

  initial begin
    int r;
    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; burst_len = '0; data_in = '0;
    m_ptr = N - 1;
    m_bid = 0;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    #2;
    chk_all_zero("por");
    @(negedge clk);
    reset_n = 1'b1;

    // single write then read by core1
    @(negedge clk);
    set_core(1, 1, 1, 'h0010, 0);
    wdata[0] = 32'hDEADBEEF;
    run_burst(0);
    set_core(1, 1, 0, 'h0010, 0);
    run_burst(0);
    chk("single_rd_data", 64'(data_out), 64'hDEADBEEF);
    chk("single_rd_bid", 64'(rburst_id), 64'd1);
    req = '0;

    // burst wrapping past the top of memory
    @(negedge clk);
    set_core(0, 1, 1, 'h00FE, 3);
    for (int i = 0; i < MB; i++) wdata[i] = DW'(i + 1);
    run_burst(0);
    set_core(0, 1, 0, 'h00FE, 3);
    run_burst(0);
    req = '0;

    // round robin with all cores requesting single beats
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < N; c++) set_core(c, 1, 1, 'h80 + c, 0);
      wdata[0] = $urandom;
      run_burst(0);
    end
    req = '0;

    // priority rotation: core2 wins alone, then core0 beats core2
    @(negedge clk);
    set_core(2, 1, 1, 'h90, 0);
    wdata[0] = $urandom;
    run_burst(0);
    req = '0;
    @(negedge clk);
    set_core(0, 1, 1, 'h91, 0);
    set_core(2, 1, 1, 'h92, 0);
    chk("rotation_pick", 64'(pick_winner(req)), 64'd0);
    run_burst(0);
    set_core(0, 0, 1, 'h91, 0);
    set_core(2, 1, 1, 'h92, 0);
    run_burst(0);
    req = '0;

    // reset during beat 1 of a 4-beat write
    @(negedge clk);
    set_core(2, 1, 1, 'h40, 3);
    for (int i = 0; i < MB; i++) wdata[i] = 32'hA0 + DW'(i);
    run_burst(0);
    set_core(2, 1, 1, 'h40, 3);
    @(posedge clk); #1;
    req = '0;
    chk("abort_gnt_b0", 64'(gnt), 64'b0100);
    chk("abort_bid", 64'(burst_id), 64'(m_bid % (1 << BW)));
    data_in[2*DW +: DW] = 32'hB0;
    @(posedge clk); #1;
    m_mem['h40] = 32'hB0;
    data_in[2*DW +: DW] = 32'hB1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr = N - 1;
    m_bid = 0;
    @(negedge clk);
    chk("after_reset_busy", 64'(busy), 64'd0);
    set_core(2, 1, 0, 'h40, 3);
    run_burst(0);
    req = '0;

    // core3 read, req dropped after the first beat
    @(negedge clk);
    set_core(3, 1, 0, 'h40, 3);
    run_burst(1);
    req = '0;

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          chk("rand_idle_gnt", 64'(gnt), 64'd0);
          chk("rand_idle_busy", 64'(busy), 64'd0);
        end
      end
      r = $urandom_range(1, (1 << N) - 1);
      for (int c = 0; c < N; c++)
        set_core(c, r[c], 1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(0, MB - 1));
      for (int i = 0; i < MB; i++) wdata[i] = $urandom;
      run_burst(1'($urandom_range(0, 1)));
    end
    req = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_mem_ctrl.md
Name: mp_mem_ctrl

Overview:
Parametrised shared-memory controller for the multiprocessor system. It arbitrates NUM_CORES request ports round-robin and executes single or burst read/write transactions against an internal word-addressed memory. Read data returns with core and burst tags. It replaces the single-port memory model used in the current system bench.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
ADDR_W, 16, per-core address width
DATA_W, 32, data word width
MEM_DEPTH, 256, memory words (power of two); index = addr[$clog2(MEM_DEPTH)-1:0]
MAX_BURST, 4, maximum beats per burst (power of two)
BID_W, 8, burst tag counter width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_CORES  per-core request, held until granted
we  in  NUM_CORES  per-core write enable (1=write burst, 0=read burst)
addr  in  NUM_CORES*ADDR_W  per-core start address, packed core0 in LSBs
burst_len  in  NUM_CORES*LEN_W  beats minus 1, LEN_W=$clog2(MAX_BURST) (min 1 bit)
data_in  in  NUM_CORES*DATA_W  per-core write data, sampled on each gnt beat
gnt  out  NUM_CORES  one-hot; high for every beat of the active burst
core_id  out  CID_W  active burst owner, CID_W=$clog2(NUM_CORES)
burst_id  out  BID_W  tag of active burst
rvalid  out  1  read data valid
data_out  out  DATA_W  read data
rcore_id  out  CID_W  owner of returned read beat
rburst_id  out  BID_W  tag of returned read beat
busy  out  1  high in BURST state

Behaviour:
- Reset (async, any time incl. mid-burst): state=IDLE, gnt=0, rvalid=0, data_out=0, core_id=0, burst_id=0, rcore_id=0, rburst_id=0, busy=0, rr_ptr=NUM_CORES-1, beat counter=0. Memory contents are not reset. An aborted burst is discarded; no further beats issue.
- FSM IDLE:
  - If req!=0, winner = first asserted req scanning from rr_ptr+1 upward, modulo NUM_CORES.
  - Latch winner's we, addr index, and burst_len.
  - Set core_id=winner and burst_id=next tag.
  - Go to BURST. gnt rises on the next cycle.
  - If req==0, stay in IDLE.
- FSM BURST:
  - gnt[core_id]=1 each cycle. Each cycle is one beat at index base+beat, which wraps modulo MEM_DEPTH.
  - Write: mem[idx] <= data_in[core_id] on that edge.
  - Read: data_out=mem[idx], rvalid=1, rcore_id/rburst_id tagged, all on the following cycle (latency 1).
  - After beat == burst_len: gnt drops, rr_ptr=core_id, state=IDLE. One mandatory idle arbitration cycle separates bursts.
- Burst length is burst_len+1 beats (1..MAX_BURST). we and addr are ignored after arbitration. Deassertion of req mid-burst is ignored; the burst always completes.
- burst_id increments by 1 per accepted burst, wraps at 2^BID_W, and the first burst after reset is 0. rvalid is a single-cycle pulse per read beat.
- Read and write to the same index in consecutive beats: the read returns the already-written value (write completes on the earlier edge).
- A core that keeps req high after its burst loses priority to any other requester in the next arbitration.

Decomposition:
- Package mp_mem_pkg: the CID_W/LEN_W derivation functions, state enum (IDLE, BURST), and a beat_tag struct {core_id, burst_id}.
- Sub-module rr_arbiter: parameter N; inputs req and ptr; output one-hot grant plus index. Combinational, reused by the interconnect.

Test Plan:
- Single write then read: core1 writes 0xDEADBEEF at addr 0x0010, len 0; core1 then reads addr 0x0010 → gnt=4'b0010 for 1 cycle per burst; read gives rvalid=1, data_out=0xDEADBEEF, rcore_id=1, rburst_id=1.
- Burst wrap: core0 writes burst_len=3 at addr 0x00FE with data 1,2,3,4, then reads it back → mem[254,255,0,1]=1,2,3,4; 4 consecutive rvalid beats 1,2,3,4, all tagged with the same rburst_id.
- Round robin: req=4'b1111 held continuously with len 0 → grant order 0,1,2,3,0; burst_id 0..4; exactly one idle cycle between gnt pulses.
- Priority rotation: core2 granted; then req=4'b0101 → core0 is granted before core2.
- Reset mid-burst: reset_n low during beat 1 of a 4-beat write → all outputs 0 asynchronously; beats 2–3 never written; after release, the next burst_id is 0.
- Req drop mid-burst: core3 read with len 3 and req deasserted after the first gnt → 4 beats are still granted and 4 rvalid pulses are returned.
